// File: rtl/serial_adder.sv
// serial_adder: adds two WIDTH-bit operands K bits per clock through a K-bit ripple chain.
// Defining SERIAL_ADDER_SUB_EN adds a 'sub' port for two's-complement subtraction.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int K     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam bit            BAD_CFG = (WIDTH < 1) || (K < 1) || (K > WIDTH) ||
                                        ((WIDTH % ((K < 1) ? 1 : K)) != 0);
    localparam int            NSTEP   = (K < 1) ? 1 : (WIDTH / K);
    localparam int            CW      = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CW-1:0] LAST    = CW'(NSTEP - 1);

    if (BAD_CFG) begin : g_param_check
        $fatal(1, "serial_adder: WIDTH must be >= 1 and K must divide WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_sha;
    logic [WIDTH-1:0] r_shb;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_b_cap;
    logic             w_c_cap;
    logic [K-1:0]     w_ksum;
    logic             w_kcout;
    logic [WIDTH-1:0] w_res_next;

    // Subtraction is a + ~b + 1, so the chain itself never changes.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_cap = sub ? ~b : b;
    assign w_c_cap = sub | cin;
`else
    assign w_b_cap = b;
    assign w_c_cap = cin;
`endif

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_cnt == LAST);

    always_comb begin
        logic c;
        c      = r_carry;
        w_ksum = '0;
        for (int unsigned i = 0; i < K; i++) begin
            w_ksum[i] = r_sha[i] ^ r_shb[i] ^ c;
            c         = (r_sha[i] & r_shb[i]) | (c & (r_sha[i] ^ r_shb[i]));
        end
        w_kcout = c;
    end

    // New K-bit slice enters at the top; after NSTEP steps the LSB slice sits at bit 0.
    assign w_res_next = (r_res >> K) | (WIDTH'(w_ksum) << (WIDTH - K));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sha   <= '0;
            r_shb   <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_sha   <= a;
            r_shb   <= w_b_cap;
            r_res   <= '0;
            r_carry <= w_c_cap;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_sha   <= r_sha >> K;
            r_shb   <= r_shb >> K;
            r_res   <= w_res_next;
            r_carry <= w_kcout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_kcout;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder that adds two WIDTH-bit operands K bits per clock.
- Uses a K-bit ripple chain of full-adder cells and a registered carry between cycles.
- Successor to the single-bit combinational full adder: same sum/carry arithmetic, now sequenced over shift registers with a start/busy/done handshake.
- Used where area matters more than latency, e.g. datapath accumulators and lab ALU stages.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 1.
- K, 1, bits processed per clock; must divide WIDTH exactly (elaboration-time check, fatal on violation).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in; captured on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking a new valid result.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  registered carry-out of the MSB.

Behaviour:
- Interface: one clock, clk; reset is rst_n, asynchronous and active-low.
- Reset: immediate on rst_n=0, independent of clk.
  - Outputs: busy=0, done=0, sum=0, cout=0.
  - Internal: state=IDLE; shift registers, carry register and counter cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: capture a, b and cin into internal registers; clear the counter; go to RUN; busy=1 from E0.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Add the K LSBs of shA and shB with the carry register through the K-bit ripple chain.
  - Carry register takes the chain carry-out.
  - shA and shB shift right by K.
  - The K result bits shift into the top of the result shift register.
  - Counter increments.
- RUN exit: after WIDTH/K RUN edges, at edge E(WIDTH/K):
  - sum takes the full result shift-register value and cout takes the final carry.
  - State goes to DONE, busy=0, done=1.
- Latency: done is high in the cycle following edge E(WIDTH/K), i.e. WIDTH/K edges after start was sampled.
- DONE (one cycle only):
  - done=1 for exactly this cycle.
  - start=1: accepted as in IDLE (back-to-back; next state RUN, busy=1, done drops).
  - start=0: go to IDLE.
- start while busy=1 is ignored. Operands are not re-captured and the operation in flight is unaffected.
- sum and cout change only at a completion edge. They hold the previous result throughout RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- Chain order within a cycle is LSB first; bit i carry feeds bit i+1.
- Reset asserted mid-RUN aborts the operation. All outputs return to reset values; no done pulse is produced.
- a, b and cin may change freely after capture.
- K=WIDTH is legal: one RUN cycle, latency 1.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds port sub (input, 1), captured with the operands on an accepted start.
  - sub=1: B is captured inverted and the initial carry is forced to 1, ignoring cin. Result is a−b, with cout=1 meaning no borrow.
  - sub=0: identical to the undefined case.
- Undefined: port absent, add only; no extra logic.

Test Plan:
- Reset, then WIDTH=8, K=1, a=0x5A, b=0x3C, cin=0, start pulse → busy for 8 cycles; done pulses once 8 edges after start; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1. sum holds 0x00 throughout the second RUN.
- start held high continuously with new operands every cycle → only the DONE-cycle starts are accepted; mid-RUN operands are ignored; results match the operands captured at acceptance; done pulses every 9 cycles.
- Deassert rst_n for 1 cycle at RUN cycle 4 → busy=0, sum=0, cout=0 immediately; no done pulse; a following start runs correctly.
- WIDTH=16, K=4, a=0x1234, b=0xEDCC, cin=0 → done 4 edges after start; sum=0x0000, cout=1. WIDTH=8, K=8 → done 1 edge after start.
- With SERIAL_ADDER_SUB_EN: sub=1, a=0x10, b=0x01 → sum=0x0F, cout=1. sub=1, a=0x01, b=0x02 → sum=0xFF, cout=0.
